// File: rtl/shiftbuffer_pkg.sv
// Shared constants for the elastic multi-lane shift buffer.
// Mode selectors and the occupancy-counter width helper.
package shiftbuffer_pkg;

  localparam int SB_RIGID    = 0;
  localparam int SB_COLLAPSE = 1;

  function automatic int sb_cnt_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/shiftbuffer_stage.sv
// One {data,valid} register of the delay line.
// Ports: i_load takes i_d/i_v, i_clr drops valid, otherwise hold; o_d/o_v state.
module shiftbuffer_stage
  import shiftbuffer_pkg::*;
#(
  parameter int p_bits = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [p_bits-1:0] i_d,
  input  logic              i_v,
  output logic [p_bits-1:0] o_d,
  output logic              o_v
);

  logic [p_bits-1:0] r_d;
  logic              r_v;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d <= '0;
      r_v <= 1'b0;
    end else begin
      if (i_load) r_d <= i_d;
      if (i_clr) r_v <= 1'b0;
      else if (i_load) r_v <= i_v;
    end
  end

  assign o_d = r_d;
  assign o_v = r_v;

endmodule

// File: rtl/shiftbuffer_elastic.sv
// Multi-lane registered delay line with ready, flush, occupancy count.
// Ports: in/in_valid/in_ready upstream, out/out_valid/i_stall downstream, o_count.
module shiftbuffer_elastic
  import shiftbuffer_pkg::*;
#(
  parameter int p_stages   = 7,
  parameter int p_width    = 8,
  parameter int p_lanes    = 2,
  parameter int p_collapse = SB_COLLAPSE
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_stall,
  input  logic                           i_flush,
  input  logic [p_lanes*p_width-1:0]     in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [p_lanes*p_width-1:0]     out,
  output logic                           out_valid,
  output logic [sb_cnt_w(p_stages)-1:0]  o_count
);

  localparam int BW = p_lanes * p_width;
  localparam int CW = sb_cnt_w(p_stages);
  localparam int LS = p_stages - 1;

  logic [BW-1:0]       w_d [p_stages];
  logic [p_stages-1:0] w_v;
  logic [p_stages-1:0] w_upd;
  logic                w_acc;
  logic                w_drn;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_cnt_nxt;

  genvar k;
  generate
    for (k = 0; k < p_stages; k++) begin : g_st
      // Stage k may take new content when the line is not stalled, or
      // (collapsing) when some stage at or beyond k is a bubble. This is
      // the unrolled form of the move chain, so there is no comb loop.
      if (p_collapse == SB_COLLAPSE) begin : g_col
        assign w_upd[k] = !i_stall || !(&w_v[LS:k]);
      end else begin : g_rig
        assign w_upd[k] = !i_stall;
      end

      if (k == 0) begin : g_head
        shiftbuffer_stage #(.p_bits(BW)) u_stage (
          .i_clk   (i_clk),
          .i_rst_n (i_rst_n),
          .i_load  (w_upd[k]),
          .i_clr   (i_flush),
          .i_d     (in),
          .i_v     (in_valid),
          .o_d     (w_d[k]),
          .o_v     (w_v[k])
        );
      end else begin : g_body
        shiftbuffer_stage #(.p_bits(BW)) u_stage (
          .i_clk   (i_clk),
          .i_rst_n (i_rst_n),
          .i_load  (w_upd[k]),
          .i_clr   (i_flush),
          .i_d     (w_d[k-1]),
          .i_v     (w_v[k-1]),
          .o_d     (w_d[k]),
          .o_v     (w_v[k])
        );
      end
    end
  endgenerate

  assign in_ready = w_upd[0];
  assign w_acc    = in_valid && w_upd[0];
  assign w_drn    = w_v[LS] && !i_stall;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_acc && !w_drn) w_cnt_nxt = r_count + CW'(1);
    else if (!w_acc && w_drn) w_cnt_nxt = r_count - CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_count <= '0;
    else if (i_flush) r_count <= '0;
    else r_count <= w_cnt_nxt;
  end

  assign out       = w_d[LS];
  assign out_valid = w_v[LS];
  assign o_count   = r_count;

endmodule

// File: tb/tb_shiftbuffer_elastic.sv
// Bench: rigid and collapsing buffers driven side by side.
// Slot-list reference model per mode; directed steps then random traffic.
module tb_shiftbuffer_elastic;
  import shiftbuffer_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_flush;
  logic [15:0] s_in [2];
  logic        s_iv [2];
  logic [15:0] d_out [2];
  logic        d_ov [2];
  logic        d_rdy [2];
  logic [2:0]  d_cnt [2];

  always #5 i_clk = ~i_clk;

  shiftbuffer_elastic #(
    .p_stages(7), .p_width(8), .p_lanes(2), .p_collapse(SB_RIGID)
  ) u_rig (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .i_flush(i_flush), .in(s_in[0]), .in_valid(s_iv[0]),
    .in_ready(d_rdy[0]), .out(d_out[0]), .out_valid(d_ov[0]),
    .o_count(d_cnt[0])
  );

  shiftbuffer_elastic #(
    .p_stages(7), .p_width(8), .p_lanes(2), .p_collapse(SB_COLLAPSE)
  ) u_col (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .i_flush(i_flush), .in(s_in[1]), .in_valid(s_iv[1]),
    .in_ready(d_rdy[1]), .out(d_out[1]), .out_valid(d_ov[1]),
    .o_count(d_cnt[1])
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          maxcnt = 0;
  bit          s_st = 0;
  bit          s_fl = 0;
  bit          mv [2][7];
  logic [15:0] md [2][7];
  logic [15:0] src [2][$];
  int          lc [2][$];
  logic [15:0] ld [2][$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bt(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, b};
  endfunction

  function automatic int mpop(input int m);
    int n = 0;
    for (int k = 0; k < 7; k++) n += int'(mv[m][k]);
    return n;
  endfunction

  // Ready: unstalled always; collapsing also while any slot is empty.
  function automatic bit mrdy(input int m, input bit st);
    bit r;
    r = !st;
    if (st && m == 1)
      for (int k = 0; k < 7; k++) if (!mv[m][k]) r = 1;
    return r;
  endfunction

  // Slots 0..h advance by one, where h is the bubble nearest the output
  // under a collapsing stall, the last slot when unstalled, none if frozen.
  task automatic madv(input int m, input bit acc, input bit st,
                      input bit fl, input logic [15:0] d);
    int h;
    h = st ? -1 : 6;
    if (st && m == 1)
      for (int k = 0; k < 7; k++) if (!mv[m][k]) h = k;
    for (int k = 6; k >= 1; k--)
      if (k <= h) begin
        mv[m][k] = mv[m][k-1];
        md[m][k] = md[m][k-1];
      end
    if (h >= 0) begin
      mv[m][0] = acc;
      md[m][0] = d;
    end
    if (fl) for (int k = 0; k < 7; k++) mv[m][k] = 0;
  endtask

  task automatic mclear();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 7; k++) begin
        mv[m][k] = 0;
        md[m][k] = '0;
      end
      src[m].delete();
    end
  endtask

  task automatic clrlog();
    for (int m = 0; m < 2; m++) begin
      lc[m].delete();
      ld[m].delete();
    end
  endtask

  task automatic step();
    bit rdy [2];
    i_stall = s_st;
    i_flush = s_fl;
    for (int m = 0; m < 2; m++) begin
      s_iv[m] = (src[m].size() > 0);
      s_in[m] = s_iv[m] ? src[m][0] : 16'($urandom);
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      rdy[m] = mrdy(m, s_st);
      chk($sformatf("in_ready[%0d]", m), 32'(d_rdy[m]), 32'(rdy[m]));
      if (d_ov[m] && !s_st) begin
        lc[m].push_back(cyc);
        ld[m].push_back(d_out[m]);
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      madv(m, s_iv[m] && rdy[m], s_st, s_fl, s_in[m]);
      if (s_iv[m] && rdy[m]) void'(src[m].pop_front());
      chk($sformatf("out_valid[%0d]", m), 32'(d_ov[m]), 32'(mv[m][6]));
      if (mv[m][6])
        chk($sformatf("out[%0d]", m), 32'(d_out[m]), 32'(md[m][6]));
      chk($sformatf("o_count[%0d]", m), 32'(d_cnt[m]), 32'(mpop(m)));
    end
    if (int'(d_cnt[1]) > maxcnt) maxcnt = int'(d_cnt[1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_stall = 1'b0;
    i_flush = 1'b0;
    for (int m = 0; m < 2; m++) begin
      s_in[m] = '0;
      s_iv[m] = 1'b0;
    end
    mclear();
    #12;
    i_rst_n = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_ov[%0d]", m), 32'(d_ov[m]), 32'd0);
      chk($sformatf("rst_cnt[%0d]", m), 32'(d_cnt[m]), 32'd0);
      chk($sformatf("rst_out[%0d]", m), 32'(d_out[m]), 32'd0);
      chk($sformatf("rst_rdy[%0d]", m), 32'(d_rdy[m]), 32'd1);
    end

    // Reset mid-stream: beat 1 is at the output when reset hits.
    for (int i = 1; i <= 4; i++)
      for (int m = 0; m < 2; m++) src[m].push_back(bt(i));
    idle(7);
    chk("pre_rst_ov", 32'(d_ov[1]), 32'd1);
    i_rst_n = 1'b0;
    #2;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("arst_ov[%0d]", m), 32'(d_ov[m]), 32'd0);
      chk($sformatf("arst_cnt[%0d]", m), 32'(d_cnt[m]), 32'd0);
    end
    mclear();
    #10;
    i_rst_n = 1'b1;
    clrlog();
    idle(10);
    chk("post_rst_log", 32'(ld[0].size() + ld[1].size()), 32'd0);

    // Back-to-back, no stall: fixed 7-cycle latency.
    maxcnt = 0;
    for (int i = 1; i <= 4; i++)
      for (int m = 0; m < 2; m++) src[m].push_back(bt(i));
    idle(6);
    chk("lat_early_ov", 32'(d_ov[1]), 32'd0);
    idle(1);
    chk("lat_ov", 32'(d_ov[1]), 32'd1);
    chk("lat_out", 32'(d_out[1]), 32'h0101);
    idle(10);
    chk("peak_cnt", 32'(maxcnt), 32'd4);

    // Bubble then stall: collapse absorbs, rigid freezes.
    for (int m = 0; m < 2; m++) src[m].push_back(bt(1));
    idle(4);
    for (int m = 0; m < 2; m++) src[m].push_back(bt(2));
    idle(1);
    s_st = 1;
    for (int i = 3; i <= 7; i++)
      for (int m = 0; m < 2; m++) src[m].push_back(bt(i));
    idle(10);
    chk("col_full_cnt", 32'(d_cnt[1]), 32'd7);
    chk("col_full_rdy", 32'(d_rdy[1]), 32'd0);
    chk("col_hold_out", 32'(d_out[1]), 32'h0101);
    chk("rig_cnt", 32'(d_cnt[0]), 32'd2);
    chk("rig_rdy", 32'(d_rdy[0]), 32'd0);
    s_st = 0;
    clrlog();
    idle(12);
    chk("col_n", 32'(ld[1].size()), 32'd7);
    if (ld[1].size() == 7)
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("col_seq%0d", i), 32'(ld[1][i]), 32'(bt(i + 1)));
        chk($sformatf("col_cyc%0d", i), 32'(lc[1][i] - lc[1][0]), 32'(i));
      end
    chk("rig_n", 32'(ld[0].size() >= 2), 32'd1);
    if (ld[0].size() >= 2) begin
      chk("rig_first", 32'(ld[0][0]), 32'h0101);
      chk("rig_second", 32'(ld[0][1]), 32'h0202);
      chk("rig_gap", 32'(lc[0][1] - lc[0][0]), 32'd4);
    end
    idle(12);

    // Flush with a beat presented in the same cycle.
    for (int m = 0; m < 2; m++) begin
      src[m].push_back(16'h1111);
      src[m].push_back(16'h2222);
    end
    idle(2);
    s_fl = 1;
    for (int m = 0; m < 2; m++) src[m].push_back(16'hAA55);
    idle(1);
    s_fl = 0;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("fl_cnt[%0d]", m), 32'(d_cnt[m]), 32'd0);
      chk($sformatf("fl_ov[%0d]", m), 32'(d_ov[m]), 32'd0);
    end
    clrlog();
    idle(10);
    chk("fl_leak", 32'(ld[0].size() + ld[1].size()), 32'd0);

    // Full line; release stall and push in the same cycle.
    for (int i = 1; i <= 7; i++)
      for (int m = 0; m < 2; m++) src[m].push_back(bt(i));
    idle(7);
    s_st = 1;
    for (int m = 0; m < 2; m++) src[m].push_back(bt(8));
    idle(1);
    for (int m = 0; m < 2; m++)
      chk($sformatf("full_rdy[%0d]", m), 32'(d_rdy[m]), 32'd0);
    s_st = 0;
    clrlog();
    idle(1);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("full_cnt[%0d]", m), 32'(d_cnt[m]), 32'd7);
      chk($sformatf("full_pend[%0d]", m), 32'(src[m].size()), 32'd0);
      chk($sformatf("full_drn_n[%0d]", m), 32'(ld[m].size()), 32'd1);
      if (ld[m].size() == 1)
        chk($sformatf("full_drn[%0d]", m), 32'(ld[m][0]), 32'h0101);
    end
    idle(10);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      s_st = ($urandom_range(0, 9) < 4);
      s_fl = ($urandom_range(0, 39) == 0);
      for (int m = 0; m < 2; m++)
        if (src[m].size() == 0 && $urandom_range(0, 2) != 0)
          src[m].push_back(16'($urandom));
      step();
    end
    s_st = 0;
    s_fl = 0;
    for (int m = 0; m < 2; m++) src[m].delete();
    idle(10);
    for (int m = 0; m < 2; m++)
      chk($sformatf("end_cnt[%0d]", m), 32'(d_cnt[m]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
